// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the register-file write-back path.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_DEPTH  = 32;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: scans from the pointer upward, pointer moves past the winner.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  int            idx;

  always_comb begin
    o_grant = '0;
    ptr_d   = ptr_q;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (o_grant == '0 && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        ptr_d        = PW'(rr_next(idx, N));
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single-write-port register file with a pending-write scoreboard.
// Define REGFILE_WB_BYPASS_EN to add commit-stage forwarding outputs o_fwd_data_1/2.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int REG_DEPTH  = regfile_pkg::REG_DEPTH,
  parameter int N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [N_REQ-1:0]            i_req_valid,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic                        o_write_en_3,
  output logic [ADDR_WIDTH-1:0]       o_addr_3,
  output logic [DATA_WIDTH-1:0]       o_write_data_3,
  input  logic                        i_issue_valid,
  input  logic [ADDR_WIDTH-1:0]       i_issue_addr,
  output logic                        o_issue_ready,
  input  logic [ADDR_WIDTH-1:0]       i_addr_1,
  input  logic [ADDR_WIDTH-1:0]       i_addr_2,
  output logic                        o_busy_1,
  output logic                        o_busy_2
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic [DATA_WIDTH-1:0]       o_fwd_data_1,
  output logic [DATA_WIDTH-1:0]       o_fwd_data_2
`endif
);

  import regfile_pkg::*;

  logic [N_REQ-1:0]      grant;
  logic                  any_grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [REG_DEPTH-1:0]  busy_q, busy_d;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .arst    (arst),
    .i_req   (i_req_valid),
    .o_grant (grant)
  );

  assign o_req_ready = grant;
  assign any_grant   = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = sel_data | i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // x0 writes are consumed by the grant but never reach the register file.
  always_comb begin
    wr_en_d = any_grant && (sel_addr != '0);
    addr_d  = any_grant ? sel_addr : addr_q;
    data_d  = any_grant ? sel_data : data_q;
  end

  assign o_issue_ready = ~busy_q[i_issue_addr];

  // Clear first, then set, so a same-cycle issue to the committing register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[addr_q] = 1'b0;
    if (i_issue_valid && o_issue_ready && i_issue_addr != '0) busy_d[i_issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign o_write_en_3   = wr_en_q;
  assign o_addr_3       = addr_q;
  assign o_write_data_3 = data_q;

`ifdef REGFILE_WB_BYPASS_EN
  logic hit_1, hit_2;
  assign hit_1        = wr_en_q && (addr_q == i_addr_1);
  assign hit_2        = wr_en_q && (addr_q == i_addr_2);
  assign o_busy_1     = busy_q[i_addr_1] & ~hit_1;
  assign o_busy_2     = busy_q[i_addr_2] & ~hit_2;
  assign o_fwd_data_1 = hit_1 ? data_q : '0;
  assign o_fwd_data_2 = hit_2 ? data_q : '0;
`else
  assign o_busy_1 = busy_q[i_addr_1];
  assign o_busy_2 = busy_q[i_addr_2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    o_req_ready;
  logic [N*AW-1:0] i_req_addr;
  logic [N*DW-1:0] i_req_data;
  logic            o_write_en_3;
  logic [AW-1:0]   o_addr_3;
  logic [DW-1:0]   o_write_data_3;
  logic            i_issue_valid;
  logic [AW-1:0]   i_issue_addr;
  logic            o_issue_ready;
  logic [AW-1:0]   i_addr_1, i_addr_2;
  logic            o_busy_1, o_busy_2;
`ifdef REGFILE_WB_BYPASS_EN
  logic [DW-1:0]   o_fwd_data_1, o_fwd_data_2;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(N)) dut (
    .clk            (clk),
    .arst           (arst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_addr     (i_req_addr),
    .i_req_data     (i_req_data),
    .o_write_en_3   (o_write_en_3),
    .o_addr_3       (o_addr_3),
    .o_write_data_3 (o_write_data_3),
    .i_issue_valid  (i_issue_valid),
    .i_issue_addr   (i_issue_addr),
    .o_issue_ready  (o_issue_ready),
    .i_addr_1       (i_addr_1),
    .i_addr_2       (i_addr_2),
    .o_busy_1       (o_busy_1),
    .o_busy_2       (o_busy_2)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .o_fwd_data_1   (o_fwd_data_1),
    .o_fwd_data_2   (o_fwd_data_2)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: round-robin pointer, scoreboard bits, and the one-cycle-delayed commit.
  int          m_ptr;
  bit          m_busy[32];
  bit          m_we;
  int          m_addr;
  logic [31:0] m_data;

  // Requesters: a pending request is held until granted.
  bit          pend[N];
  int          p_addr[N];
  logic [31:0] p_data[N];

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 0;
    m_addr = 0;
    m_data = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      i_req_valid[i]          = pend[i];
      i_req_addr[i*AW +: AW]  = AW'(p_addr[i]);
      i_req_data[i*DW +: DW]  = p_data[i];
    end
  endtask

  task automatic exp_busy(input int a, output bit b, output logic [31:0] fwd);
    bit hit;
    hit = m_we && (m_addr == a);
`ifdef REGFILE_WB_BYPASS_EN
    b   = m_busy[a] && !hit;
    fwd = hit ? m_data : 32'h0;
`else
    b   = m_busy[a];
    fwd = 32'h0;
`endif
  endtask

  // Called at a falling edge with stimulus set; checks, crosses one rising edge, returns at the next falling edge.
  task automatic step();
    int          g;
    int          ia;
    bit          set_ok;
    bit          b1, b2;
    logic [31:0] f1, f2;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    check_eq("req_ready", o_req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    check_eq("write_en", o_write_en_3, m_we);
    check_eq("write_addr", o_addr_3, m_addr);
    check_eq("write_data", o_write_data_3, m_data);
    ia = int'(i_issue_addr);
    check_eq("issue_ready", o_issue_ready, !m_busy[ia]);
    exp_busy(int'(i_addr_1), b1, f1);
    exp_busy(int'(i_addr_2), b2, f2);
    check_eq("busy_1", o_busy_1, b1);
    check_eq("busy_2", o_busy_2, b2);
`ifdef REGFILE_WB_BYPASS_EN
    check_eq("fwd_1", o_fwd_data_1, f1);
    check_eq("fwd_2", o_fwd_data_2, f2);
`endif
    set_ok = i_issue_valid && !m_busy[ia] && ia != 0;
    @(posedge clk);
    if (m_we) m_busy[m_addr] = 0;
    if (set_ok) m_busy[ia] = 1;
    if (g >= 0) begin
      m_we    = (p_addr[g] != 0);
      m_addr  = p_addr[g];
      m_data  = p_data[g];
      m_ptr   = (g + 1) % N;
      pend[g] = 0;
    end else begin
      m_we = 0;
    end
    @(negedge clk);
  endtask

  task automatic post(input int i, input int a, input logic [31:0] d);
    pend[i]   = 1;
    p_addr[i] = a;
    p_data[i] = d;
  endtask

  task automatic issue(input bit v, input int a);
    i_issue_valid = v;
    i_issue_addr  = AW'(a);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; p_addr[i] = 0; p_data[i] = '0;
    end
    i_req_valid = '0; i_req_addr = '0; i_req_data = '0;
    issue(0, 0);
    i_addr_1 = '0; i_addr_2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    arst = 1'b0;

    // Idle after reset
    step();
    check_eq("idle_we", o_write_en_3, 1'b0);
    check_eq("idle_issue_ready", o_issue_ready, 1'b1);

    // Issue x5, write it back three cycles later
    i_addr_1 = 5; issue(1, 5);
    step();
    issue(0, 0);
    check_eq("x5_busy_c1", o_busy_1, 1'b1);
    step(); step();
    post(0, 5, 32'hDEADBEEF);
    step();
    check_eq("x5_we_c4", o_write_en_3, 1'b1);
    check_eq("x5_addr_c4", o_addr_3, 5);
    check_eq("x5_data_c4", o_write_data_3, 32'hDEADBEEF);
`ifdef REGFILE_WB_BYPASS_EN
    check_eq("x5_busy_c4", o_busy_1, 1'b0);
    check_eq("x5_fwd_c4", o_fwd_data_1, 32'hDEADBEEF);
`else
    check_eq("x5_busy_c4", o_busy_1, 1'b1);
`endif
    step();
    check_eq("x5_busy_c5", o_busy_1, 1'b0);

    // Both requesters continuously valid
    for (int c = 0; c < 8; c++) begin
      if (!pend[0]) post(0, 1, 32'h11);
      if (!pend[1]) post(1, 2, 32'h22);
      step();
    end
    while (pend[0] || pend[1]) step();

    // WAW block, then set-wins on a same-cycle commit
    i_addr_1 = 7; issue(1, 7);
    step();
    step();
    check_eq("waw_busy_held", o_busy_1, 1'b1);
    issue(0, 0);
    post(0, 7, 32'h77);
    step();
    step();
    check_eq("x7_cleared", o_busy_1, 1'b0);
    post(1, 7, 32'h78);
    step();
    issue(1, 7);
    step();
    issue(0, 0);
    check_eq("set_wins", o_busy_1, 1'b1);

    // x0 writes and issues
    i_addr_1 = 0; i_addr_2 = 0;
    post(0, 0, 32'hFFFFFFFF); issue(1, 0);
    step();
    issue(0, 0);
    check_eq("x0_we", o_write_en_3, 1'b0);
    check_eq("x0_busy", o_busy_1, 1'b0);
    step();

    // Reset mid-operation
    i_addr_1 = 3; issue(1, 3);
    step();
    issue(0, 0);
    post(0, 9, 32'h99);
    step();
    post(1, 4, 32'h44);
    drive();
    arst = 1'b1;
    #1;
    check_eq("rst_we", o_write_en_3, 1'b0);
    check_eq("rst_addr", o_addr_3, 0);
    check_eq("rst_data", o_write_data_3, 0);
    check_eq("rst_busy", o_busy_1, 1'b0);
    model_reset();
    @(negedge clk);
    arst = 1'b0;
    step();
    check_eq("rst_regrant_addr", o_addr_3, 4);
    check_eq("rst_regrant_we", o_write_en_3, 1'b1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          post(i, int'($urandom_range(0, 7)), $urandom);
      issue($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
      i_addr_1 = AW'($urandom_range(0, 7));
      i_addr_2 = AW'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
